// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-fetch request channel between the PC sequencer (master) and
// instruction memory (slave).
interface pc_fetch_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] fetch_addr;

  modport master (output fetch_valid, output fetch_addr, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_addr, output fetch_ready);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: FETCH/HALT FSM around a load/increment PC.
// Optional return stack enabled by defining PC_CALL_STACK_EN.
module pc_fetch_sequencer #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      STACK_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    halt_req,
  input  logic                    jump_en,
  input  logic [WIDTH-1:0]        jump_addr,
  input  logic                    call_en,
  input  logic                    ret_en,
  pc_fetch_sequencer_if.master    bus,
  output logic [1:0]              state,
  output logic                    wrap,
  output logic                    stack_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t           cur_state, next_state;
  logic [WIDTH-1:0] pc, pc_next, pc_inc;
  logic [WIDTH-1:0] target, target_next, req_target, eff_target;
  logic             pending, pending_next, req_take, eff_pending;
  logic             hs, wrap_next;

  assign pc_inc          = pc + WIDTH'(1);
  assign bus.fetch_addr  = pc;
  assign bus.fetch_valid = (cur_state == FETCH);
  assign state           = cur_state;
  assign hs              = (cur_state == FETCH) && bus.fetch_ready;

`ifdef PC_CALL_STACK_EN
  localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SPW-1:0]   sp;
  logic             push, pop, err_set, err_q, full, empty;

  assign full      = (sp == SPW'(STACK_DEPTH));
  assign empty     = (sp == '0);
  assign stack_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (^{call_en, ret_en}) ^ (STACK_DEPTH == 0);
  assign stack_err  = 1'b0;
`endif

  // Decode at most one request per edge; a rejected call/ret also drops jump_en.
  always_comb begin
    req_take   = 1'b0;
    req_target = target;
`ifdef PC_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (ret_en) begin
      if (empty) begin
        err_set = 1'b1;
      end else begin
        pop        = 1'b1;
        req_take   = 1'b1;
        req_target = stack_mem[IDXW'(sp - SPW'(1))];
      end
    end else if (call_en) begin
      if (full) begin
        err_set = 1'b1;
      end else begin
        push       = 1'b1;
        req_take   = 1'b1;
        req_target = jump_addr;
      end
    end else if (jump_en) begin
      req_take   = 1'b1;
      req_target = jump_addr;
    end
`else
    if (jump_en) begin
      req_take   = 1'b1;
      req_target = jump_addr;
    end
`endif
  end

  // A request arriving on a handshake edge takes effect in that same update.
  always_comb begin
    eff_pending  = req_take | pending;
    eff_target   = req_take ? req_target : target;
    next_state   = cur_state;
    pc_next      = pc;
    pending_next = eff_pending;
    target_next  = eff_target;
    wrap_next    = 1'b0;
    unique case (cur_state)
      IDLE, HALTED: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        if (hs) begin
          pc_next      = eff_pending ? eff_target : pc_inc;
          pending_next = 1'b0;
          wrap_next    = !eff_pending && (pc == '1);
          if (halt_req) next_state = HALTED;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      pc        <= RESET_VECTOR;
      pending   <= 1'b0;
      target    <= '0;
      wrap      <= 1'b0;
    end else begin
      cur_state <= next_state;
      pc        <= pc_next;
      pending   <= pending_next;
      target    <= target_next;
      wrap      <= wrap_next;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (err_set)  err_q <= 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (push) stack_mem[IDXW'(sp)] <= pc_inc;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed vector bench for pc_fetch_sequencer (state updates on falling edge).
module tb_pc_fetch_sequencer;

  logic        clk, rst_n, run, halt_req, jump_en, call_en, ret_en;
  logic [15:0] jump_addr;
  logic [1:0]  state;
  logic        wrap, stack_err;
  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_fetch_sequencer_if #(.WIDTH(16)) bus ();

  pc_fetch_sequencer #(
    .WIDTH(16), .RESET_VECTOR(16'h0000), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .jump_en(jump_en), .jump_addr(jump_addr), .call_en(call_en),
    .ret_en(ret_en), .bus(bus), .state(state), .wrap(wrap),
    .stack_err(stack_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic run, halt, jmp; logic [15:0] ja; logic call, ret, rdy;
    logic ev; logic [15:0] ea; logic [1:0] es; logic ew, ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic h, logic j, logic [15:0] ja,
                              logic c, logic rt, logic rdy, logic ev,
                              logic [15:0] ea, logic [1:0] es, logic ew, logic ee);
    vec_t v;
    v.run = r; v.halt = h; v.jmp = j; v.ja = ja; v.call = c; v.ret = rt;
    v.rdy = rdy; v.ev = ev; v.ea = ea; v.es = es; v.ew = ew; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [15:0] ea,
                            input logic [1:0] es, input logic ew, input logic ee);
    check({tag, "_valid"}, 32'(bus.fetch_valid), 32'(ev));
    check({tag, "_addr"},  32'(bus.fetch_addr),  32'(ea));
    check({tag, "_state"}, 32'(state),           32'(es));
    check({tag, "_wrap"},  32'(wrap),            32'(ew));
    check({tag, "_err"},   32'(stack_err),       32'(ee));
  endtask

  task automatic apply(input vec_t v, input int unsigned idx);
    run = v.run; halt_req = v.halt; jump_en = v.jmp; jump_addr = v.ja;
    call_en = v.call; ret_en = v.ret; bus.fetch_ready = v.rdy;
    @(negedge clk); #1;
    check_outs($sformatf("v%0d", idx), v.ev, v.ea, v.es, v.ew, v.ee);
  endtask

  initial begin
    rst_n = 1'b0; run = 0; halt_req = 0; jump_en = 0; jump_addr = '0;
    call_en = 0; ret_en = 0; bus.fetch_ready = 0;

    //               run h j  ja       c r rdy ev ea       st    w e
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 2'b01, 0, 0));
    for (int unsigned a = 1; a <= 5; a++)
      vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'(a), 2'b01, 0, 0));
    for (int unsigned k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0005, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0006, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0007, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0100, 0, 0, 0, 1, 16'h0007, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0007, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0100, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0101, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'hFFFF, 0, 0, 1, 1, 16'hFFFF, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 2'b01, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'hFFFF, 0, 0, 1, 1, 16'hFFFF, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 1, 1, 16'h0000, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0009, 0, 0, 1, 1, 16'h0009, 2'b01, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 1, 0, 16'h000A, 2'b10, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 0, 1, 0, 16'h000A, 2'b10, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 1, 16'h000A, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0040, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0041, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0300, 0, 0, 0, 1, 16'h0041, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0350, 0, 0, 0, 1, 16'h0041, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0350, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0500, 0, 0, 0, 1, 16'h0350, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0600, 0, 0, 1, 1, 16'h0600, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0601, 2'b01, 0, 0));
`ifdef PC_CALL_STACK_EN
    // Call/return round trip, then overflow on the fifth nested call.
    vecs.push_back(mk(1, 0, 1, 16'h0010, 0, 0, 1, 1, 16'h0010, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0200, 1, 0, 0, 1, 16'h0010, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0200, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0011, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0200, 1, 0, 1, 1, 16'h0200, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0300, 1, 0, 1, 1, 16'h0300, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0400, 1, 0, 1, 1, 16'h0400, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0500, 1, 0, 1, 1, 16'h0500, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0600, 1, 0, 1, 1, 16'h0501, 2'b01, 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0401, 2'b01, 0, 1));
`else
    // Without the stack, call/ret are inert and jump_en still works alongside them.
    vecs.push_back(mk(1, 0, 0, 16'h0200, 1, 0, 1, 1, 16'h0602, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0700, 1, 0, 1, 1, 16'h0700, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0701, 2'b01, 0, 0));
`endif

    repeat (2) @(negedge clk);
    #1 check_outs("reset", 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_outs("idle", 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Stall, then reset asserted between edges must clear outputs immediately.
    bus.fetch_ready = 1'b0; call_en = 0; ret_en = 0; jump_en = 0;
    @(negedge clk); #3;
    check("stall_valid", 32'(bus.fetch_valid), 32'd1);
    rst_n = 1'b0;
    #1 check_outs("async_rst", 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    @(negedge clk); #1;
    check_outs("post_rst", 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
